result_serial_tx: RTL and testbench

Transmit-side counterpart of the host-to-chip configuration shift register. Buffers 4-bit Mandelbrot iteration results in a small FIFO, one word per data_valid pulse (issued when running falls). Serializes the words back to the RP2040, MSB first, on a single output pin. The RP2040 paces every bit with a slow, asynchronous shift strobe. The block sits beside the Mandelbrot engine and drives one dedicated output in binary-interface mode.

---
 rtl/result_tx_pkg.sv | 11 +
 rtl/result_serial_tx_if.sv | 26 ++
 rtl/result_tx_fifo.sv | 67 ++++++
 rtl/result_serial_tx.sv | 133 +++++++++++++
 tb/tb_result_serial_tx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/result_tx_pkg.sv
// Shared types and default sizing for the result serial transmitter.
package result_tx_pkg;
  localparam int RTX_DATAWIDTH = 4;
  localparam int RTX_DEPTH     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
endpackage

// File: rtl/result_serial_tx_if.sv
// Engine/host-facing signal bundle for result_serial_tx; the slave modport is the transmitter side.
interface result_serial_tx_if import result_tx_pkg::*; #(
  parameter int DATAWIDTH = RTX_DATAWIDTH,
  parameter int ADDRWIDTH = $clog2(RTX_DEPTH)
);
  logic [DATAWIDTH-1:0] data_in;
  logic                 data_valid;
  logic                 clear;
  logic                 sclk_in;
  logic                 sdo;
  logic                 busy;
  logic                 empty;
  logic                 full;
  logic [ADDRWIDTH:0]   fill_level;
  logic                 overflow;

  modport master (
    output data_in, data_valid, clear, sclk_in,
    input  sdo, busy, empty, full, fill_level, overflow
  );

  modport slave (
    input  data_in, data_valid, clear, sclk_in,
    output sdo, busy, empty, full, fill_level, overflow
  );
endinterface

// File: rtl/result_tx_fifo.sv
// Pointer/count FIFO: combinational head read, registered flags and level; caller never pushes when full
// unless popping in the same cycle. Also exposes next-cycle emptiness so the sender can register sdo against it.
module result_tx_fifo import result_tx_pkg::*; #(
  parameter int DATAWIDTH = RTX_DATAWIDTH,
  parameter int DEPTH     = RTX_DEPTH,
  parameter int ADDRWIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] head,
  output logic                 empty,
  output logic                 empty_next,
  output logic                 full,
  output logic [ADDRWIDTH:0]   level
);
  localparam logic [ADDRWIDTH:0] ONE      = (ADDRWIDTH+1)'(1);
  localparam logic [ADDRWIDTH:0] FULL_LVL = (ADDRWIDTH+1)'(DEPTH);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRWIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDRWIDTH:0]   level_next;

  assign head = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (clear)
      level_next = '0;
    else if (push && !pop)
      level_next = level + ONE;
    else if (pop && !push)
      level_next = level - ONE;
  end

  assign empty_next = (level_next == '0);

  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      level <= level_next;
      empty <= empty_next;
      full  <= (level_next == FULL_LVL);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/result_serial_tx.sv
// Buffers result words and shifts them MSB-first to the host, one bit per synchronized sclk_in rise (3 clk rise-to-effect).
// Optional even-parity bit after each word when RESULT_TX_PARITY_EN is defined.
module result_serial_tx import result_tx_pkg::*; #(
  parameter int DATAWIDTH = RTX_DATAWIDTH,
  parameter int DEPTH     = RTX_DEPTH,
  parameter int ADDRWIDTH = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  result_serial_tx_if.slave bus
);
  localparam int CNTW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  logic                 s_meta, s_sync, s_prev, rise;
  state_t               state, state_next;
  logic [DATAWIDTH-1:0] shreg, shreg_next;
  logic [CNTW-1:0]      cnt, cnt_next;
  logic                 sdo_next, busy_next;
  logic                 pop, push, drop;
  logic                 overflow_q, sdo_q, busy_q;
  logic [DATAWIDTH-1:0] head;
  logic                 fifo_empty, fifo_empty_next, fifo_full;
  logic [ADDRWIDTH:0]   fifo_level;
`ifdef RESULT_TX_PARITY_EN
  logic                 par, par_next;
`endif

  assign rise = s_sync & ~s_prev;
  assign push = bus.data_valid & (~fifo_full | pop) & ~bus.clear;
  assign drop = bus.data_valid & fifo_full & ~pop & ~bus.clear;

  result_tx_fifo #(
    .DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .ADDRWIDTH(ADDRWIDTH)
  ) u_fifo (
    .clk(clk), .rst_n(rst_n), .clear(bus.clear),
    .push(push), .push_data(bus.data_in), .pop(pop),
    .head(head), .empty(fifo_empty), .empty_next(fifo_empty_next),
    .full(fifo_full), .level(fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta     <= 1'b0;
      s_sync     <= 1'b0;
      s_prev     <= 1'b0;
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef RESULT_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      s_meta     <= bus.sclk_in;
      s_sync     <= s_meta;
      s_prev     <= s_sync;
      state      <= state_next;
      shreg      <= shreg_next;
      cnt        <= cnt_next;
      sdo_q      <= sdo_next;
      busy_q     <= busy_next;
      overflow_q <= bus.clear ? 1'b0 : (overflow_q | drop);
`ifdef RESULT_TX_PARITY_EN
      par        <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    pop        = 1'b0;
`ifdef RESULT_TX_PARITY_EN
    par_next   = par;
`endif
    if (bus.clear) begin
      state_next = IDLE;
    end else if (rise) begin
      case (state)
        IDLE: if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = head;
          cnt_next   = CNTW'(DATAWIDTH - 1);
          state_next = SHIFT;
`ifdef RESULT_TX_PARITY_EN
          par_next   = ^head;
`endif
        end
        SHIFT: if (cnt != '0) begin
          shreg_next = shreg << 1;
          cnt_next   = cnt - 1'b1;
        end else begin
`ifdef RESULT_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // sdo is registered from the next state so it lines up with busy and the FIFO flags.
  always_comb begin
    sdo_next  = 1'b0;
    busy_next = 1'b0;
    case (state_next)
      IDLE:  sdo_next = ~fifo_empty_next;
      SHIFT: begin
        sdo_next  = shreg_next[DATAWIDTH-1];
        busy_next = 1'b1;
      end
`ifdef RESULT_TX_PARITY_EN
      PARITY: begin
        sdo_next  = par_next;
        busy_next = 1'b1;
      end
`endif
      default: sdo_next = 1'b0;
    endcase
  end

  assign bus.sdo        = sdo_q;
  assign bus.busy       = busy_q;
  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.fill_level = fifo_level;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_result_serial_tx.sv
// Scoreboard bench for result_serial_tx: a word-queue/bit-list host model predicts each sdo sample.
module tb_result_serial_tx;
  import result_tx_pkg::*;

  localparam int DW    = RTX_DATAWIDTH;
  localparam int DEPTH = RTX_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  result_serial_tx_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus();

  result_serial_tx #(.DATAWIDTH(DW), .DEPTH(DEPTH), .ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  bit              exp_q[$];
  logic [DW-1:0]   m_fifo[$];
  bit              m_frame[$];
  bit              m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_sdo();
    if (m_frame.size() != 0) return m_frame[0];
    return m_fifo.size() != 0;
  endfunction

  task automatic model_push(input logic [DW-1:0] w);
    if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
    else m_ovf = 1'b1;
  endtask

  // Host view: each rise samples sdo; an idle rise with data starts a new frame.
  task automatic model_rise();
    logic [DW-1:0] w;
    exp_q.push_back(model_sdo());
    if (m_frame.size() != 0) begin
      void'(m_frame.pop_front());
    end else if (m_fifo.size() != 0) begin
      w = m_fifo.pop_front();
      for (int i = DW - 1; i >= 0; i--) m_frame.push_back(w[i]);
`ifdef RESULT_TX_PARITY_EN
      m_frame.push_back(^w);
`endif
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".sdo"},   bus.sdo,        model_sdo());
    check({tag, ".busy"},  bus.busy,       m_frame.size() != 0);
    check({tag, ".empty"}, bus.empty,      m_fifo.size() == 0);
    check({tag, ".full"},  bus.full,       m_fifo.size() == DEPTH);
    check({tag, ".level"}, bus.fill_level, m_fifo.size());
    check({tag, ".ovf"},   bus.overflow,   m_ovf);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    model_push(w);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
  endtask

  // Optional push lands in the same clk as the DUT's reaction to this rise.
  task automatic host_rise(input bit with_push, input logic [DW-1:0] w);
    model_rise();
    if (with_push) model_push(w);
    bus.sclk_in = 1'b1;
    repeat (2) @(posedge clk); #1;
    if (with_push) begin
      bus.data_in    = w;
      bus.data_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus.sclk_in = 1'b0;
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    m_fifo.delete();
    m_frame.delete();
    m_ovf = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge bus.sclk_in);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sdo_sample: rise with no expectation queued at %0t", $time);
      end else begin
        check("sdo_sample", bus.sdo, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int op;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.clear      = 1'b0;
    bus.sclk_in    = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_status("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) host_rise(1'b0, '0);
    check_status("idle_rises");

    push_word(4'hA);
    check_status("push_a");
    for (int i = 0; i < 5; i++) host_rise(1'b0, '0);
    check_status("after_a");

    push_word(4'h3);
    push_word(4'hC);
    for (int i = 0; i < 10; i++) host_rise(1'b0, '0);
    check_status("after_3c");

    for (int i = 0; i < DEPTH + 1; i++) push_word(DW'($urandom));
    check_status("overfill");
    for (int i = 0; i < DEPTH * (DW + 1) + 1; i++) host_rise(1'b0, '0);
    check_status("drained");

    clear_pulse();
    for (int i = 0; i < DEPTH; i++) push_word(DW'($urandom));
    host_rise(1'b1, DW'($urandom));
    check_status("push_on_pop");

    host_rise(1'b0, '0);
    host_rise(1'b0, '0);
    clear_pulse();
    check_status("clear_mid");
    host_rise(1'b0, '0);
    check_status("after_clear");

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 19);
      if (op < 7)       push_word(DW'($urandom));
      else if (op < 19) host_rise(op[0], DW'($urandom));
      else              clear_pulse();
      check_status("random");
    end

    clear_pulse();
    check_status("final");
    repeat (2) @(posedge clk); #1;
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
